// File: rtl/axis_pattern_gen_if.sv
// AXI-Stream bundle carried between the pattern generator and its sink.
// The master drives data and qualifiers. The slave returns tready.
interface axis_if #(
    parameter int BYTE_WIDTH = 4
) ();
    logic                      tvalid;
    logic                      tready;
    logic [8*BYTE_WIDTH-1:0]   tdata;
    logic [BYTE_WIDTH-1:0]     tstrb;
    logic [BYTE_WIDTH-1:0]     tkeep;
    logic                      tlast;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast,
        output tready
    );
endinterface

// File: rtl/axis_pattern_gen.sv
// AXI-Stream source that emits an arithmetic sequence (start, step, wrap limit) split into packets.
//   state   | meaning
//   ST_IDLE | no traffic; tvalid low; waiting for i_enable
//   ST_RUN  | streaming beats; returns to idle only after a tlast handshake with i_enable low
module axis_pattern_gen #(
    parameter int BYTE_WIDTH = 4,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      i_enable,
    input  logic [8*BYTE_WIDTH-1:0]   i_cfg_start,
    input  logic [8*BYTE_WIDTH-1:0]   i_cfg_step,
    input  logic [8*BYTE_WIDTH-1:0]   i_cfg_limit,
    input  logic [LEN_WIDTH-1:0]      i_cfg_pkt_len,
    axis_if.master                    m_axis,
    output logic                      o_busy,
    output logic [CNT_WIDTH-1:0]      o_pkt_count
);

    localparam int DW = 8*BYTE_WIDTH;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    logic                   r_tvalid;
    logic                   r_tlast;
    logic [DW-1:0]          r_tdata;
    logic [LEN_WIDTH-1:0]   r_beat_idx;
    logic [CNT_WIDTH-1:0]   r_pkt_count;

    // Shadow copy of the configuration. It is held constant for the whole packet.
    logic [DW-1:0]          r_start;
    logic [DW-1:0]          r_step;
    logic [DW-1:0]          r_limit;
    logic [LEN_WIDTH-1:0]   r_last_idx;

    logic                   w_hs;
    logic [DW:0]            w_sum;
    logic [DW-1:0]          w_next;
    logic [LEN_WIDTH-1:0]   w_cfg_last_idx;
    logic [LEN_WIDTH-1:0]   w_beat_inc;

    assign w_hs           = r_tvalid && m_axis.tready;
    // The carry bit is kept so that an overflowing sum counts as exceeding the limit.
    assign w_sum          = {1'b0, r_tdata} + {1'b0, r_step};
    assign w_next         = (w_sum > {1'b0, r_limit}) ? r_start : w_sum[DW-1:0];
    assign w_cfg_last_idx = (i_cfg_pkt_len == '0) ? '0 : (i_cfg_pkt_len - LEN_ONE);
    assign w_beat_inc     = r_beat_idx + LEN_ONE;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tdata     <= '0;
            r_beat_idx  <= '0;
            r_pkt_count <= '0;
            r_start     <= '0;
            r_step      <= '0;
            r_limit     <= '0;
            r_last_idx  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_enable) begin
                        r_state    <= ST_RUN;
                        r_tvalid   <= 1'b1;
                        r_tdata    <= i_cfg_start;
                        r_tlast    <= (w_cfg_last_idx == '0);
                        r_beat_idx <= '0;
                        r_start    <= i_cfg_start;
                        r_step     <= i_cfg_step;
                        r_limit    <= i_cfg_limit;
                        r_last_idx <= w_cfg_last_idx;
                    end
                end
                ST_RUN: begin
                    if (w_hs) begin
                        if (r_tlast) begin
                            r_pkt_count <= r_pkt_count + CNT_ONE;
                            r_beat_idx  <= '0;
                            r_start     <= i_cfg_start;
                            r_step      <= i_cfg_step;
                            r_limit     <= i_cfg_limit;
                            r_last_idx  <= w_cfg_last_idx;
                            if (i_enable) begin
                                // The sequence continues across the packet boundary.
                                r_tdata <= w_next;
                                r_tlast <= (w_cfg_last_idx == '0);
                            end else begin
                                r_state  <= ST_IDLE;
                                r_tvalid <= 1'b0;
                                r_tlast  <= 1'b0;
                            end
                        end else begin
                            r_beat_idx <= w_beat_inc;
                            r_tdata    <= w_next;
                            r_tlast    <= (w_beat_inc == r_last_idx);
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_tvalid <= 1'b0;
                    r_tlast  <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tlast  = r_tlast;
    assign m_axis.tstrb  = '1;
    assign m_axis.tkeep  = '1;
    assign o_busy        = (r_state == ST_RUN);
    assign o_pkt_count   = r_pkt_count;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Directed bench for axis_pattern_gen. It runs a table of sequence vectors.
// Hand-written sequences cover backpressure, early enable drop and reset in the middle of a packet.
module tb_axis_pattern_gen;

    logic          clk;
    logic          resetn;
    logic          enable;
    logic [31:0]   cfg_start;
    logic [31:0]   cfg_step;
    logic [31:0]   cfg_limit;
    logic [15:0]   cfg_pkt_len;
    logic          busy;
    logic [31:0]   pkt_count;

    int n_err;
    int n_chk;

    axis_if #(.BYTE_WIDTH(4)) ax ();

    axis_pattern_gen #(
        .BYTE_WIDTH(4),
        .LEN_WIDTH (16),
        .CNT_WIDTH (32)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_enable     (enable),
        .i_cfg_start  (cfg_start),
        .i_cfg_step   (cfg_step),
        .i_cfg_limit  (cfg_limit),
        .i_cfg_pkt_len(cfg_pkt_len),
        .m_axis       (ax.master),
        .o_busy       (busy),
        .o_pkt_count  (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]         start;
        logic [31:0]         step;
        logic [31:0]         limit;
        logic [15:0]         len;
        logic [0:7][31:0]    exp_data;
        logic [0:7]          exp_last;
        int                  exp_cnt;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        enable      = 1'b0;
        ax.tready   = 1'b1;
        cfg_start   = '0;
        cfg_step    = '0;
        cfg_limit   = '0;
        cfg_pkt_len = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic set_cfg(input logic [31:0] s, input logic [31:0] st,
                           input logic [31:0] l, input logic [15:0] n);
        cfg_start   = s;
        cfg_step    = st;
        cfg_limit   = l;
        cfg_pkt_len = n;
    endtask

    task automatic drain(input string name);
        int n;
        n         = 0;
        enable    = 1'b0;
        ax.tready = 1'b1;
        while (ax.tvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_tvalid"}, 32'(ax.tvalid), 32'd0);
        chk({name, "_drain_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [39:0] pat;
        logic [31:0] exp;
        logic        hs;

        n_err = 0;
        n_chk = 0;

        tbl[0] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 16'd4,
                   {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7},
                   8'b0001_0001, 2};
        tbl[1] = '{32'd10, 32'd5, 32'd22, 16'd8,
                   {32'd10, 32'd15, 32'd20, 32'd10, 32'd15, 32'd20, 32'd10, 32'd15},
                   8'b0000_0001, 1};
        tbl[2] = '{32'd7, 32'd0, 32'd100, 16'd0,
                   {32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7},
                   8'b1111_1111, 8};
        tbl[3] = '{32'd50, 32'd3, 32'd20, 16'd3,
                   {32'd50, 32'd50, 32'd50, 32'd50, 32'd50, 32'd50, 32'd50, 32'd50},
                   8'b0010_0100, 2};
        tbl[4] = '{32'hFFFF_FFF0, 32'd8, 32'hFFFF_FFFF, 16'd2,
                   {32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'hFFFF_FFF0, 32'hFFFF_FFF8,
                    32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'hFFFF_FFF0, 32'hFFFF_FFF8},
                   8'b0101_0101, 4};
        tbl[5] = '{32'd1, 32'd2, 32'd7, 16'd5,
                   {32'd1, 32'd3, 32'd5, 32'd7, 32'd1, 32'd3, 32'd5, 32'd7},
                   8'b0000_1000, 1};

        // Reset state
        do_reset();
        chk("rst_tvalid", 32'(ax.tvalid), 32'd0);
        chk("rst_tlast", 32'(ax.tlast), 32'd0);
        chk("rst_tdata", ax.tdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pkt_count", pkt_count, 32'd0);
        chk("rst_tstrb", 32'(ax.tstrb), 32'hF);
        chk("rst_tkeep", 32'(ax.tkeep), 32'hF);

        // Table vectors with tready held high, so one beat is sent per cycle
        for (int v = 0; v < 6; v++) begin
            do_reset();
            set_cfg(tbl[v].start, tbl[v].step, tbl[v].limit, tbl[v].len);
            enable = 1'b1;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                chk($sformatf("v%0d_b%0d_tvalid", v, k), 32'(ax.tvalid), 32'd1);
                chk($sformatf("v%0d_b%0d_tdata", v, k), ax.tdata, tbl[v].exp_data[k]);
                chk($sformatf("v%0d_b%0d_tlast", v, k), 32'(ax.tlast), 32'(tbl[v].exp_last[k]));
            end
            @(negedge clk);
            chk($sformatf("v%0d_pkt_count", v), pkt_count, 32'(tbl[v].exp_cnt));
            drain($sformatf("v%0d", v));
        end

        // Pseudo-random backpressure: data must hold and no beat may be skipped
        do_reset();
        set_cfg(32'd0, 32'd1, 32'hFFFF_FFFF, 16'd4);
        enable = 1'b1;
        pat = 40'b1011_0010_0111_0001_1100_1101_0100_1111_0110_1001;
        exp = 32'd0;
        hs  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (hs) exp = exp + 32'd1;
            chk($sformatf("bp%0d_tvalid", i), 32'(ax.tvalid), 32'd1);
            chk($sformatf("bp%0d_tdata", i), ax.tdata, exp);
            chk($sformatf("bp%0d_tlast", i), 32'(ax.tlast), 32'(exp[1:0] == 2'd3));
            ax.tready = pat[i];
            hs = ax.tvalid && ax.tready;
        end
        @(negedge clk);
        if (hs) exp = exp + 32'd1;
        chk("bp_pkt_count", pkt_count, exp >> 2);
        drain("bp");

        // enable is dropped partway through the packet; the packet still runs to its tlast
        do_reset();
        set_cfg(32'd0, 32'd1, 32'hFFFF_FFFF, 16'd4);
        enable = 1'b1;
        @(negedge clk);
        chk("en_b0_tdata", ax.tdata, 32'd0);
        @(negedge clk);
        chk("en_b1_tdata", ax.tdata, 32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("en_b2_tdata", ax.tdata, 32'd2);
        chk("en_b2_busy", 32'(busy), 32'd1);
        chk("en_b2_tlast", 32'(ax.tlast), 32'd0);
        @(negedge clk);
        chk("en_b3_tdata", ax.tdata, 32'd3);
        chk("en_b3_tlast", 32'(ax.tlast), 32'd1);
        @(negedge clk);
        chk("en_end_tvalid", 32'(ax.tvalid), 32'd0);
        chk("en_end_busy", 32'(busy), 32'd0);
        chk("en_end_pkt_count", pkt_count, 32'd1);

        // Async reset in the middle of a packet, then a restart from cfg_start
        do_reset();
        set_cfg(32'h55, 32'd1, 32'hFFFF_FFFF, 16'd4);
        enable = 1'b1;
        repeat (6) @(negedge clk);
        chk("mr_pre_tvalid", 32'(ax.tvalid), 32'd1);
        chk("mr_pre_tdata", ax.tdata, 32'h5A);
        chk("mr_pre_pkt_count", pkt_count, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("mr_tvalid", 32'(ax.tvalid), 32'd0);
        chk("mr_tdata", ax.tdata, 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_pkt_count", pkt_count, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("mr_restart_tvalid", 32'(ax.tvalid), 32'd1);
        chk("mr_restart_tdata", ax.tdata, 32'h55);
        chk("mr_restart_pkt_count", pkt_count, 32'd0);
        drain("mr");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
